// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and IF/ID output register with redirect, drain/halt and misalign handling
module fetch_unit #(
    parameter int PC_SIZE = 32,
    parameter int INSTR_SIZE = 32,
    parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic [PC_SIZE-1:0]    fetch_pc_o,
    input  logic [INSTR_SIZE-1:0] instr_i,
    input  logic                  done_i,
    input  logic                  redirect_i,
    input  logic [PC_SIZE-1:0]    redirect_pc_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [PC_SIZE-1:0]    pc_o,
    output logic [INSTR_SIZE-1:0] instr_o,
    output logic [PC_SIZE-1:0]    pc_plus4_o,
    output logic                  halted_o,
    output logic                  misalign_o
);
    typedef enum logic [1:0] {FETCH, DRAIN, HALT} state_t;
    state_t state, state_n;
    logic [PC_SIZE-1:0] pc, pc_n, pc_inc;
    logic valid_n, mis_n, load, accept, space;
    assign pc_inc = pc + PC_SIZE'(4);
    assign accept = valid_o & ready_i;
    assign space = !valid_o | ready_i;
    assign fetch_pc_o = pc;
    assign halted_o = (state == HALT);
    always_comb begin
        state_n = state;
        pc_n = pc;
        valid_n = valid_o;
        mis_n = misalign_o;
        load = 1'b0;
        if (redirect_i && !misalign_o) begin
            valid_n = 1'b0;
            if (redirect_pc_i[1:0] == 2'b00) begin
                pc_n = redirect_pc_i;
                state_n = FETCH;
            end else begin
                mis_n = 1'b1;
                state_n = HALT;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (!done_i) begin
                        if (space) begin
                            load = 1'b1;
                            valid_n = 1'b1;
                            pc_n = pc_inc;
                        end
                    end else begin
                        if (accept) valid_n = 1'b0;
                        state_n = (!valid_o || accept) ? HALT : DRAIN;
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        valid_n = 1'b0;
                        state_n = HALT;
                    end
                end
                HALT: valid_n = 1'b0;
                default: state_n = HALT;
            endcase
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= FETCH;
            pc <= RESET_PC;
            valid_o <= 1'b0;
            pc_o <= '0;
            instr_o <= '0;
            pc_plus4_o <= '0;
            misalign_o <= 1'b0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            valid_o <= valid_n;
            misalign_o <= mis_n;
            if (load) begin
                instr_o <= instr_i;
                pc_o <= pc;
                pc_plus4_o <= pc_inc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random and directed stimulus against a behavioural fetch model
module tb_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1, redir = 1'b0, ready = 1'b0;
    logic [31:0] rpc = '0, prog_end = 32'h10;
    logic [31:0] fpc0, fpc1, instr0, instr1, pc0, pc1, ins0, ins1, p40, p41;
    logic done0, done1, val0, val1, hlt0, hlt1, mis0, mis1;
    int n_checks = 0, n_fail = 0;

    typedef struct {
        logic [31:0] pc, opc, oinstr, opc4;
        bit valid, halted, draining, mis;
    } mdl_t;
    mdl_t m0, m1;

    function automatic logic [31:0] rd_instr(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_1234;
    endfunction
    function automatic logic rd_done(logic [31:0] a, logic [31:0] e);
        return (a >= e) && (a < 32'hF000_0000);
    endfunction

    assign instr0 = rd_instr(fpc0);
    assign instr1 = rd_instr(fpc1);
    assign done0 = rd_done(fpc0, prog_end);
    assign done1 = rd_done(fpc1, prog_end);

    fetch_unit #(.RESET_PC(32'h0)) u0 (
        .clk_i(clk), .rst_i(rst), .fetch_pc_o(fpc0), .instr_i(instr0), .done_i(done0),
        .redirect_i(redir), .redirect_pc_i(rpc), .ready_i(ready), .valid_o(val0),
        .pc_o(pc0), .instr_o(ins0), .pc_plus4_o(p40), .halted_o(hlt0), .misalign_o(mis0));
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u1 (
        .clk_i(clk), .rst_i(rst), .fetch_pc_o(fpc1), .instr_i(instr1), .done_i(done1),
        .redirect_i(redir), .redirect_pc_i(rpc), .ready_i(ready), .valid_o(val1),
        .pc_o(pc1), .instr_o(ins1), .pc_plus4_o(p41), .halted_o(hlt1), .misalign_o(mis1));

    // One clock of the fetch stage described as: held slot, halted/draining flags, sticky error
    function automatic mdl_t step(mdl_t m, logic [31:0] rp);
        mdl_t n = m;
        if (rst) begin
            n.pc = rp; n.opc = 0; n.oinstr = 0; n.opc4 = 0;
            n.valid = 0; n.halted = 0; n.draining = 0; n.mis = 0;
        end else if (redir && !m.mis) begin
            n.valid = 0; n.draining = 0;
            if (rpc % 4 == 0) begin n.pc = rpc; n.halted = 0; end
            else begin n.mis = 1; n.halted = 1; end
        end else if (m.halted) begin
            n.valid = 0;
        end else if (m.draining) begin
            if (m.valid && ready) begin n.valid = 0; n.halted = 1; n.draining = 0; end
        end else if (!rd_done(m.pc, prog_end)) begin
            if (!m.valid || ready) begin
                n.opc = m.pc; n.oinstr = rd_instr(m.pc); n.opc4 = m.pc + 4;
                n.valid = 1; n.pc = m.pc + 4;
            end
        end else if (!m.valid || ready) begin
            n.valid = 0; n.halted = 1;
        end else begin
            n.draining = 1;
        end
        return n;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_unit(string u, mdl_t m, logic [31:0] fpc, logic v, logic [31:0] p,
                              logic [31:0] ins, logic [31:0] p4, logic h, logic mi);
        check({u, ".fetch_pc"}, fpc, m.pc);
        check({u, ".valid"}, 32'(v), 32'(m.valid));
        check({u, ".pc"}, p, m.opc);
        check({u, ".instr"}, ins, m.oinstr);
        check({u, ".pc_plus4"}, p4, m.opc4);
        check({u, ".halted"}, 32'(h), 32'(m.halted));
        check({u, ".misalign"}, 32'(mi), 32'(m.mis));
    endtask

    task automatic cyc(bit r, bit rd, logic [31:0] t, bit rdy);
        @(negedge clk);
        rst = r; redir = rd; rpc = t; ready = rdy;
        @(posedge clk);
        m0 = step(m0, 32'h0);
        m1 = step(m1, 32'hFFFF_FFFC);
        #1;
        check_unit("u0", m0, fpc0, val0, pc0, ins0, p40, hlt0, mis0);
        check_unit("u1", m1, fpc1, val1, pc1, ins1, p41, hlt1, mis1);
    endtask

    initial begin
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);
        prog_end = 32'h100;
        cyc(0, 1, 32'h40, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 32'h80, 0);
        prog_end = 32'h88;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
        prog_end = 32'h100;
        cyc(0, 1, 32'h22, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 32'h0, 1);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            int k;
            k = int'($urandom_range(0, 9));
            t = (k < 7) ? 32'($urandom_range(0, 63)) * 4 :
                (k < 9) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4 : $urandom;
            if ($urandom_range(0, 99) == 0) prog_end = 32'($urandom_range(0, 80)) * 4;
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 9) == 0, t, $urandom_range(0, 3) != 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage that sits directly upstream of the instruction reader. Owns the program counter and drives the fetch address to the reader. Samples the returned instruction and done flag in the same cycle; the reader's read path is combinational.
- Holds the fetched instruction in an IF/ID output register with a valid/ready handshake toward decode.
- Handles branch/jump redirects, end-of-program drain and halt, and misaligned-target errors.

Parameters:
- PC_SIZE, 32, width of all PC/address values
- INSTR_SIZE, 32, instruction width
- RESET_PC, 0, PC value loaded on reset (must be 4-byte aligned)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- fetch_pc_o  out  PC_SIZE  address to instruction reader (equals PC register)
- instr_i  in  INSTR_SIZE  instruction returned by reader for fetch_pc_o, same cycle
- done_i  in  1  reader reports no instruction at fetch_pc_o
- redirect_i  in  1  taken branch/jump from execute, single-cycle pulse
- redirect_pc_i  in  PC_SIZE  redirect target
- ready_i  in  1  decode accepts the output register this cycle
- valid_o  out  1  output register holds a valid instruction
- pc_o  out  PC_SIZE  address of the instruction in the output register
- instr_o  out  INSTR_SIZE  instruction in the output register
- pc_plus4_o  out  PC_SIZE  pc_o + 4, modulo 2^PC_SIZE
- halted_o  out  1  fetch stopped: end of program or error
- misalign_o  out  1  sticky: a redirect target had bits [1:0] != 0

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset values (take effect at the first clk_i edge with rst_i=1, overriding all other inputs):
  - PC = RESET_PC; state = FETCH
  - valid_o = 0; pc_o = 0; instr_o = 0; pc_plus4_o = 0
  - halted_o = 0; misalign_o = 0
- Reset mid-operation discards any held instruction.
- States are FETCH, DRAIN and HALT; halted_o = (state == HALT), registered.
- Definitions:
  - accept = valid_o & ready_i
  - space = !valid_o | ready_i
- Priority each cycle, highest first: rst_i, then redirect_i, then state logic.
- Redirect, aligned target (redirect_pc_i[1:0] == 0), in any state:
  - PC <= redirect_pc_i; valid_o <= 0, flushing the held instruction even if ready_i=1; state <= FETCH.
  - instr_i is ignored that cycle.
- Redirect, misaligned target: misalign_o <= 1, valid_o <= 0, PC unchanged, state <= HALT.
- misalign_o stays set until reset; while it is set, further redirects are ignored and the block stays in HALT.
- FETCH, done_i=0, space=1 (load):
  - instr_o <= instr_i; pc_o <= PC; pc_plus4_o <= PC+4
  - valid_o <= 1; PC <= PC+4, wrapping 0xFFFFFFFC -> 0x00000000
- FETCH, done_i=0, space=0 (stall): PC and the output register hold; instr_i is ignored.
- FETCH, done_i=1: no load, PC holds. If accept, valid_o <= 0. Then:
  - next state = HALT if !valid_o or accept
  - otherwise next state = DRAIN
- DRAIN: PC holds; on accept, valid_o <= 0 and state <= HALT.
- HALT: PC holds, valid_o = 0, fetch_pc_o continues to show PC; only a valid redirect or reset leaves HALT.
- Latency: the instruction at fetch_pc_o appears on instr_o one cycle later.
- Throughput: one instruction per cycle while ready_i=1.
- Output register fields never change while valid_o=1 and ready_i=0.
- All arithmetic is unsigned PC_SIZE-bit, carry discarded.

Test Plan:
- Straight-line fetch: reset with RESET_PC=0, reader holds 4 instructions at 0x0..0xC, ready_i=1.
  - Required: valid_o high from cycle 1 with pc_o = 0x0, 0x4, 0x8, 0xC on consecutive cycles and matching instr_o.
  - Required: done_i at 0x10; halted_o=1 the cycle after the 0xC instruction is accepted.
- Stall: drop ready_i for 3 cycles while pc_o=0x4.
  - Required: pc_o/instr_o/valid_o frozen and fetch_pc_o=0x8 throughout; after ready_i rises, next pc_o=0x8.
- Redirect during stall: valid_o=1, ready_i=0, redirect_i with target 0x40.
  - Required: next cycle valid_o=0 and fetch_pc_o=0x40; following cycle pc_o=0x40, valid_o=1.
- Drain: done_i asserted while valid_o=1 and ready_i=0 for 2 cycles.
  - Required: halted_o stays 0 during DRAIN; halted_o=1 the cycle after ready_i=1, with valid_o=0.
- Misaligned redirect: target 0x22.
  - Required: misalign_o=1 and halted_o=1 next cycle, valid_o=0; a later aligned redirect to 0x0 is ignored; rst_i clears both flags.
- Wrap: RESET_PC=0xFFFFFFFC.
  - Required: first pc_o=0xFFFFFFFC with pc_plus4_o=0x0; next fetch_pc_o=0x0.
  - Required: asserting rst_i mid-stream returns fetch_pc_o to RESET_PC and clears valid_o the next cycle.
